muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/adder_32bit.sv | 13 +
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and a conditional-negate helper for the iterative mul/div unit.
// Pure declarations: no latency, no flow control.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam int         XLEN      = 32;
  localparam logic [4:0] LAST_ITER = 5'd31;

  // Two's-complement negate when neg is set; doubles as absolute value.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple adder with carry in/out, shared by the mul/div iteration step.
// Combinational, zero latency; no flow control.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers; 34 edges from accepting start to done.
// No queuing: start is taken only in IDLE, MTHI/MTLO only in IDLE/DONE; busy flags RUN and FIN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic               is_div;
  logic               accept;
  logic [2*WIDTH-1:0] acc_sh;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   add_a, add_b, add_s;
  logic               add_ci, add_co;
  logic               div_ok;
  logic               in_sgn, a_neg, b_neg;

  assign is_div = op_q[1];
  assign accept = (state_q == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_ITER) state_d = S_FIN;
      S_FIN:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_FIN);
    done = (state_q == S_DONE);
  end

  // Multiply adds the multiplicand into the upper half; divide subtracts the
  // divisor from the left-shifted remainder (~b with cin=1).
  always_comb begin
    acc_sh = {acc_q[2*WIDTH-2:0], 1'b0};
    if (is_div) begin
      add_a  = acc_sh[2*WIDTH-1:WIDTH];
      add_b  = ~opb_q;
      add_ci = 1'b1;
    end else begin
      add_a  = acc_q[2*WIDTH-1:WIDTH];
      add_b  = opb_q;
      add_ci = 1'b0;
    end
  end

  adder_32bit u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co)
  );

  // The bit shifted out of the remainder makes it 33 bits wide, so it also
  // guarantees the subtract succeeds.
  always_comb begin
    div_ok = acc_q[2*WIDTH-1] | add_co;
    if (is_div)
      acc_step = div_ok ? {add_s, acc_sh[WIDTH-1:1], 1'b1} : acc_sh;
    else
      acc_step = acc_q[0] ? {add_co, add_s, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    prod = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  end

  always_comb begin
    in_sgn    = ~op[0];
    a_neg     = in_sgn & a[WIDTH-1];
    b_neg     = in_sgn & b[WIDTH-1];
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (accept) begin
      op_d      = op_e'(op);
      cnt_d     = 5'd0;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      div0_d    = op[1] & (b == '0);
      if (op[1]) begin
        acc_d = {{WIDTH{1'b0}}, cond_neg(a, a_neg)};
        opb_d = cond_neg(b, b_neg);
      end else begin
        acc_d = {{WIDTH{1'b0}}, cond_neg(b, b_neg)};
        opb_d = cond_neg(a, a_neg);
      end
    end else if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
      if (hi_we) hi_d = wd;
      if (lo_we) lo_d = wd;
    end else if (state_q == S_RUN) begin
      acc_d = acc_step;
      cnt_d = cnt_q + 5'd1;
    end else begin
      if (is_div) begin
        hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
        lo_d = div0_q ? {WIDTH{1'b1}} : cond_neg(acc_q[WIDTH-1:0], neg_res_q);
      end else begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_MULT;
      cnt_q     <= 5'd0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus randomized ops against a 64-bit arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wd = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      2'b00: p = sx * sy;
      2'b01: p = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one op from IDLE (caller sits 1ns after an edge); returns results seen
  // while done is high and the edge count from accept to done. Ends back in IDLE.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] h, output logic [31:0] l, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    h = hi;
    l = lo;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_directed();
    logic [31:0] h, l;
    int lat;
    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, h, l, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL mult_latency got=%0d want=34", lat); end
    total++; if (h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", h); end
    total++; if (l !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h want=ffffffeb", l); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_single_pulse got=%b want=0", done); end
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, lat);
    total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", h); end
    total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", l); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, h, l, lat);
    total++; if (l !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", l); end
    total++; if (h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", h); end
    do_op(2'b11, 32'd100, 32'd0, h, l, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL divu0_latency got=%0d want=34", lat); end
    total++; if (l !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_lo got=%h want=ffffffff", l); end
    total++; if (h !== 32'h0000_0064) begin bad++; $display("FAIL divu0_hi got=%h want=00000064", h); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l, lat);
    total++; if (l !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h want=80000000", l); end
    total++; if (h !== 32'h0000_0000) begin bad++; $display("FAIL div_ovf_hi got=%h want=00000000", h); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, h, l, lat);
    total++; if (l !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h want=ffffffff", l); end
    total++; if (h !== 32'hFFFF_FFF9) begin bad++; $display("FAIL div0_hi got=%h want=fffffff9", h); end
  endtask

  task automatic test_random();
    logic [31:0] x, y, h, l;
    logic [1:0]  o;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick_operand();
      y = pick_operand();
      exp = ref_model(o, x, y);
      do_op(o, x, y, h, l, lat);
      total++; if (lat != 34) begin bad++; $display("FAIL rand_latency op=%0d got=%0d want=34", o, lat); end
      total++; if ({h, l} !== exp) begin
        bad++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h_%h want=%h", o, x, y, h, l, exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] exp;
    int dones, dedge, guard;
    exp = ref_model(2'b11, 32'd1000, 32'd7);
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; dedge = -1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5) begin op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin dones++; dedge = e; end
    end
    total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
    total++; if (dedge != 33) begin bad++; $display("FAIL ignore_done_edge got=%0d want=33", dedge); end
    total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL ignore_result got=%h_%h want=%h", hi, lo, exp); end
    // start presented during the DONE cycle must also be dropped
    op = 2'b00; a = 32'd5; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 60) begin @(posedge clk); #1; guard++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_wait_timeout got=%b want=1", done); end
    op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done_idle got=%b want=0", busy); end
    total++; if (lo !== 32'd45) begin bad++; $display("FAIL start_in_done_lo got=%h want=0000002d", lo); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] h, l;
    int lat, dones;
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL abort_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL abort_lo got=%h want=0", lo); end
    @(posedge clk); #1;
    reset = 1'b1;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL abort_hilo got=%h_%h want=0", hi, lo); end
    // start is accepted on the very first edge after reset releases
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    do_op(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFF0, h, l, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL first_edge_latency got=%0d want=34", lat); end
    total++; if ({h, l} !== 64'd256) begin bad++; $display("FAIL first_edge_result got=%h_%h want=256", h, l); end
  endtask

  task automatic test_mthi_mtlo();
    int guard;
    hi_we = 1'b1; wd = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_idle got=%h want=12345678", hi); end
    lo_we = 1'b1; wd = 32'hCAFE_F00D;
    @(posedge clk); #1;
    lo_we = 1'b0;
    total++; if (lo !== 32'hCAFE_F00D) begin bad++; $display("FAIL mtlo_idle got=%h want=cafef00d", lo); end
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mtlo_keeps_hi got=%h want=12345678", hi); end
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1; hi_we = 1'b1; wd = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL start_priority_hi got=%h want=12345678", hi); end
    repeat (3) @(posedge clk);
    #1;
    hi_we = 1'b0;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_busy got=%h want=12345678", hi); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mthi_busy_flag got=%b want=1", busy); end
    guard = 0;
    while (done !== 1'b1 && guard < 60) begin @(posedge clk); #1; guard++; end
    total++; if ({hi, lo} !== 64'd15) begin bad++; $display("FAIL mthi_busy_result got=%h_%h want=15", hi, lo); end
    hi_we = 1'b1; wd = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    total++; if (hi !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mthi_done got=%h want=a5a5a5a5", hi); end
    total++; if (lo !== 32'd15) begin bad++; $display("FAIL mthi_done_lo got=%h want=0000000f", lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_mthi_mtlo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
